// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: ALU select codes, FSM states
// and the illegal-select test used when the response is captured.
package alu_arbiter_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  function automatic logic sel_illegal(input logic [2:0] sel);
    logic bad;
    bad = 1'b1;
    case (sel)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT: bad = 1'b0;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first asserted request strictly
// after the `last` index, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 3,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            any
);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    // Scan from the farthest candidate back to the nearest so the nearest wins.
    for (int k = NREQ; k >= 1; k--) begin
      if (req[(int'(last) + k) % NREQ]) begin
        grant                               = '0;
        grant[(int'(last) + k) % NREQ]      = 1'b1;
        grant_idx                           = IDW'((int'(last) + k) % NREQ);
        any                                 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NREQ requesters: round-robin grant in IDLE, one
// cycle of ALU evaluation in EXEC, registered result held in RESP.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int WIDTH = 32,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_op1,
  input  logic [NREQ*WIDTH-1:0] req_op2,
  input  logic [NREQ*3-1:0]     req_sel,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]      rsp_resultado,
  output logic                  rsp_zf,
  output logic                  rsp_err,
  output logic [WIDTH-1:0]      alu_operand1,
  output logic [WIDTH-1:0]      alu_operand2,
  output logic [2:0]            alu_sel,
  input  logic [WIDTH-1:0]      alu_resultado,
  input  logic                  alu_zf,
  output logic                  busy,
  output logic [IDW-1:0]        grant_id
);

  // Handshake: a request transfers on the cycle req_valid[i] & req_ready[i];
  // a response transfers on the cycle rsp_valid[i] & rsp_ready[i].
  state_t           state_q, state_d;
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_idx;
  logic             any;
  logic [IDW-1:0]   last_q, gid_q;
  logic [WIDTH-1:0] op1_q, op2_q, res_q;
  logic [2:0]       sel_q;
  logic             zf_q, err_q;
  logic             accept, capture;
  logic [NREQ-1:0]  owner_oh;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req       (req_valid),
    .last      (last_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any)
  );

  assign owner_oh = NREQ'(1) << gid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    capture   = 1'b0;
    req_ready = '0;
    rsp_valid = '0;
    case (state_q)
      S_IDLE: begin
        if (any) begin
          req_ready = grant;
          accept    = 1'b1;
          state_d   = S_EXEC;
        end
      end
      S_EXEC: begin
        capture = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid = owner_oh;
        // Only the owner's rsp_ready can retire the response.
        if (|(rsp_ready & owner_oh)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op1_q  <= '0;
      op2_q  <= '0;
      sel_q  <= '0;
      last_q <= IDW'(NREQ - 1);
      gid_q  <= '0;
      res_q  <= '0;
      zf_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (accept) begin
        op1_q  <= req_op1[grant_idx*WIDTH +: WIDTH];
        op2_q  <= req_op2[grant_idx*WIDTH +: WIDTH];
        sel_q  <= req_sel[grant_idx*3 +: 3];
        last_q <= grant_idx;
        gid_q  <= grant_idx;
      end
      if (capture) begin
        res_q <= alu_resultado;
        zf_q  <= alu_zf;
        err_q <= sel_illegal(sel_q);
      end
    end
  end

  assign alu_operand1  = op1_q;
  assign alu_operand2  = op2_q;
  assign alu_sel       = sel_q;
  assign rsp_resultado = res_q;
  assign rsp_zf        = zf_q;
  assign rsp_err       = err_q;
  assign busy          = (state_q != S_IDLE);
  assign grant_id      = gid_q;

endmodule
